md_unit_ctrl: RTL and testbench
===============================

# md_unit_ctrl

Multiply/divide scheduler for the pipelined CPU. It sits in the E stage beside the ALU and owns the HI/LO registers. It launches the multi-cycle mult/multu/div/divu operations, counts their latency, and commits their results. It also raises a stall request so the hazard unit holds any md-class instruction in D while the unit is occupied.

## Interface
Parameters:
- MUL_CYC, 5, busy cycles for mult/multu (≥1)
- DIV_CYC, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; all state cleared on a clk edge with reset=0
- e_en  in  1  E-stage instruction valid (not bubble, not flushed)
- e_md_op  in  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9–15 treated as none
- e_rs  in  32  forwarded rs value
- e_rt  in  32  forwarded rt value
- d_is_md  in  1  D-stage instruction is any of ops 1–8
- start  out  1  combinational: e_en & op∈{1..4} & !busy
- busy  out  1  registered: an operation is in flight
- stall_req  out  1  combinational: d_is_md & (start | busy)
- md_rd  out  32  combinational: HI when op=7, LO when op=8, else 0
- hi, lo  out  32  architectural HI/LO registers

## Operation
- State: cnt (4 bits, holds up to DIV_CYC), pend_hi/pend_lo (32 each), hi/lo (32 each). busy = (cnt≠0).
- Start at cycle t (start=1). Edge ending t does the following:
  - Loads cnt with MUL_CYC for ops 1–2 or DIV_CYC for ops 3–4.
  - Loads pend_hi/pend_lo with the result computed from e_rs/e_rt sampled in cycle t.
- Results:
  - mult: signed 64-bit product; {pend_hi,pend_lo} = rs*rt.
  - multu: same, unsigned.
  - div: pend_lo = signed quotient truncated toward zero; pend_hi = remainder with the sign of the dividend.
  - divu: pend_lo = unsigned quotient; pend_hi = unsigned remainder.
- Divide by zero (rt=0): cnt is still loaded. HI/LO are left unchanged at commit; no error is signalled.
- Overflow case div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Busy phase: each edge with cnt>1 decrements cnt. On the edge with cnt==1, cnt<=0 and hi/lo<=pend_hi/pend_lo.
- mthi/mtlo (e_en & op 5/6 & !busy): hi (resp. lo) <= e_rs on that edge.
- mfhi/mflo: md_rd reflects the current registered hi/lo. No bypass of an in-flight result.
- Any op 1–6 arriving with busy=1 is ignored: no state change, start=0. A correct hazard unit never allows this; the bench checks it is harmless.
- Reset (reset=0 at an edge): cnt=0, hi=lo=pend_hi=pend_lo=0. Any in-flight result is discarded, including one whose commit edge coincides with reset.

## Timing
- Reset values: busy=0, hi=0, lo=0. start, stall_req and md_rd follow their inputs (0 when e_en=0 and d_is_md=0).
- mult at cycle t:
  - busy=1 for cycles t+1..t+MUL_CYC.
  - New hi/lo visible from cycle t+MUL_CYC+1, the same cycle busy falls.
- div: the same with DIV_CYC.
- stall_req:
  - Asserted in cycle t (through start) and in every busy cycle whenever d_is_md=1.
  - The first non-stalled cycle for a following mfhi in D is t+MUL_CYC+1. It reaches E at t+MUL_CYC+2 and reads committed data.
- Back-to-back: a second mult may start in the first cycle busy=0. No idle gap is required.
- mthi at cycle t: hi visible at t+1. An mfhi in E at t+1 returns the new value.
- Simultaneous reset and start: reset wins; busy=0 next cycle.
- e_en=0 suppresses start and mthi/mtlo writes regardless of e_md_op. The in-flight count continues.

## Test plan
- mult: rs=0xFFFFFFFE (−2), rt=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu: same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div: rs=−7, rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- divu: rs=7, rt=0 -> busy 10 cycles; hi/lo keep prior values 0x11/0x22 written by mthi/mtlo.
- Stall: mult in E with d_is_md=1 held -> stall_req=1 for 6 consecutive cycles (start + 5 busy), 0 on the 7th. A mult issued while busy=1 leaves the pending result unchanged.
- Reset at busy cycle 3 of div -> busy=0 the next cycle, hi=lo=0, no commit afterwards. Also check mthi 0xDEADBEEF then mfhi one cycle later -> md_rd=0xDEADBEEF.

Source files
------------

// File: rtl/md_unit_ctrl.sv
// Multiply/divide scheduler: launches mult/div, counts latency, owns HI/LO.
// Also raises stall_req so md-class instructions wait in D while busy.
module md_unit_ctrl #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_en,
    input  logic [3:0]  e_md_op,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_is_md,
    output logic        start,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] md_rd,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam logic [3:0] MUL_LD = 4'(MUL_CYC);
    localparam logic [3:0] DIV_LD = 4'(DIV_CYC);

    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_launch_op;
    logic        is_div_op;
    logic        div_signed;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign is_launch_op = (e_md_op >= OP_MULT) && (e_md_op <= OP_DIVU);
    assign is_div_op    = (e_md_op == OP_DIV) || (e_md_op == OP_DIVU);
    assign div_signed   = (e_md_op == OP_DIV);

    assign busy      = (cnt_q != 4'd0);
    assign start     = e_en && is_launch_op && !busy;
    assign stall_req = d_is_md && (start || busy);
    assign hi        = hi_q;
    assign lo        = lo_q;

    assign prod_s = {{32{e_rs[31]}}, e_rs} * {{32{e_rt[31]}}, e_rt};
    assign prod_u = {32'd0, e_rs} * {32'd0, e_rt};

    // Signed divide works on magnitudes; a zero divisor is replaced so the
    // datapath never produces X, its result is never committed anyway.
    assign dvd_mag = (div_signed && e_rs[31]) ? -e_rs : e_rs;
    assign dvs_mag = (e_rt == 32'd0) ? 32'd1 :
                     ((div_signed && e_rt[31]) ? -e_rt : e_rt);
    assign quo_mag = dvd_mag / dvs_mag;
    assign rem_mag = dvd_mag % dvs_mag;
    assign quo     = (div_signed && (e_rs[31] ^ e_rt[31])) ? -quo_mag : quo_mag;
    assign rem     = (div_signed && e_rs[31]) ? -rem_mag : rem_mag;

    always_comb begin
        md_rd = 32'd0;
        if (e_md_op == OP_MFHI) begin
            md_rd = hi_q;
        end else if (e_md_op == OP_MFLO) begin
            md_rd = lo_q;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (busy) begin
            // Ops arriving while busy are dropped; only the countdown advances.
            if (cnt_q == 4'd1) begin
                cnt_d = 4'd0;
                if (pend_wr_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end else if (start) begin
            cnt_d = is_div_op ? DIV_LD : MUL_LD;
            pend_wr_d = 1'b1;
            case (e_md_op)
                OP_MULT: {pend_hi_d, pend_lo_d} = prod_s;
                OP_MULTU: {pend_hi_d, pend_lo_d} = prod_u;
                default: begin
                    pend_hi_d = rem;
                    pend_lo_d = quo;
                    pend_wr_d = (e_rt != 32'd0);
                end
            endcase
        end else if (e_en && (e_md_op == OP_MTHI)) begin
            hi_d = e_rs;
        end else if (e_en && (e_md_op == OP_MTLO)) begin
            lo_d = e_rs;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= 4'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Bench for md_unit_ctrl: directed scenarios with literal expectations, then
// random traffic compared each cycle against a cycle-numbered reference model.
module tb_md_unit_ctrl;

    localparam int MUL_CYC = 5;
    localparam int DIV_CYC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_en;
    logic [3:0]  e_md_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_is_md;
    logic        start;
    logic        busy;
    logic        stall_req;
    logic [31:0] md_rd;
    logic [31:0] hi;
    logic [31:0] lo;

    md_unit_ctrl #(.MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk       (clk),
        .reset     (reset),
        .e_en      (e_en),
        .e_md_op   (e_md_op),
        .e_rs      (e_rs),
        .e_rt      (e_rt),
        .d_is_md   (d_is_md),
        .start     (start),
        .busy      (busy),
        .stall_req (stall_req),
        .md_rd     (md_rd),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model: busy means the current cycle number lies inside the window
    // (launch cycle, busy_until]; the result lands on the edge ending busy_until.
    int          busy_until = -1;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_pend_hi = 32'd0;
    logic [31:0] m_pend_lo = 32'd0;
    bit          m_pend_ok = 1'b0;

    logic        s_busy, s_start, s_stall;
    logic [31:0] s_md_rd, s_hi, s_lo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_result(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                output logic [31:0] rh, output logic [31:0] rl, output bit ok);
        longint a, b, p;
        logic [63:0] pu;
        ok = 1'b1;
        rh = 32'd0;
        rl = 32'd0;
        case (op)
            4'd1: begin
                a = longint'(int'(rs));
                b = longint'(int'(rt));
                p = a * b;
                {rh, rl} = p;
            end
            4'd2: begin
                pu = {32'd0, rs} * {32'd0, rt};
                {rh, rl} = pu;
            end
            4'd3: begin
                if (rt == 32'd0) begin
                    ok = 1'b0;
                end else begin
                    a = longint'(int'(rs));
                    b = longint'(int'(rt));
                    rl = 32'(a / b);
                    rh = 32'(a % b);
                end
            end
            default: begin
                if (rt == 32'd0) begin
                    ok = 1'b0;
                end else begin
                    rl = rs / rt;
                    rh = rs % rt;
                end
            end
        endcase
    endtask

    task automatic apply_stimulus(input logic rst_n, input logic en, input logic [3:0] op,
                                  input logic [31:0] rs, input logic [31:0] rt, input logic dmd);
        reset   = rst_n;
        e_en    = en;
        e_md_op = op;
        e_rs    = rs;
        e_rt    = rt;
        d_is_md = dmd;
    endtask

    task automatic check_output();
        bit          m_busy, x_start;
        logic [31:0] x_rd;
        m_busy  = (cyc <= busy_until);
        x_start = e_en && (e_md_op >= 4'd1) && (e_md_op <= 4'd4) && !m_busy;
        x_rd    = (e_md_op == 4'd7) ? m_hi : ((e_md_op == 4'd8) ? m_lo : 32'd0);
        s_busy  = busy;
        s_start = start;
        s_stall = stall_req;
        s_md_rd = md_rd;
        s_hi    = hi;
        s_lo    = lo;
        check("busy", s_busy, m_busy);
        check("start", s_start, x_start);
        check("stall_req", s_stall, d_is_md && (x_start || m_busy));
        check("md_rd", s_md_rd, x_rd);
        check("hi", s_hi, m_hi);
        check("lo", s_lo, m_lo);
    endtask

    task automatic model_update();
        bit m_busy;
        m_busy = (cyc <= busy_until);
        if (!reset) begin
            busy_until = -1;
            m_hi = 32'd0;
            m_lo = 32'd0;
            m_pend_hi = 32'd0;
            m_pend_lo = 32'd0;
            m_pend_ok = 1'b0;
        end else if (m_busy) begin
            if (cyc == busy_until && m_pend_ok) begin
                m_hi = m_pend_hi;
                m_lo = m_pend_lo;
            end
        end else if (e_en) begin
            if (e_md_op >= 4'd1 && e_md_op <= 4'd4) begin
                busy_until = cyc + ((e_md_op <= 4'd2) ? MUL_CYC : DIV_CYC);
                model_result(e_md_op, e_rs, e_rt, m_pend_hi, m_pend_lo, m_pend_ok);
            end else if (e_md_op == 4'd5) begin
                m_hi = e_rs;
            end else if (e_md_op == 4'd6) begin
                m_lo = e_rs;
            end
        end
    endtask

    task automatic run_cycle(input logic rst_n, input logic en, input logic [3:0] op,
                             input logic [31:0] rs, input logic [31:0] rt, input logic dmd);
        apply_stimulus(rst_n, en, op, rs, rt, dmd);
        @(negedge clk);
        check_output();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic idle(input logic dmd);
        run_cycle(1'b1, 1'b1, 4'd0, 32'd0, 32'd0, dmd);
    endtask

    // Launch an op, then count busy cycles over a fixed window.
    task automatic launch_and_count(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                    input int window, output int nbusy);
        run_cycle(1'b1, 1'b1, op, rs, rt, 1'b0);
        nbusy = 0;
        for (int i = 0; i < window; i++) begin
            idle(1'b0);
            if (s_busy) nbusy++;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'(int'($urandom_range(0, 20)) - 10);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nbusy;
        int nstall;
        apply_stimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        run_cycle(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        idle(1'b0);
        check("reset_busy", s_busy, 32'd0);
        check("reset_hi", s_hi, 32'd0);
        check("reset_lo", s_lo, 32'd0);
        check("reset_stall", s_stall, 32'd0);

        launch_and_count(4'd1, 32'hFFFF_FFFE, 32'd3, 8, nbusy);
        check("mult_busy_len", 32'(nbusy), 32'd5);
        check("mult_hi", s_hi, 32'hFFFF_FFFF);
        check("mult_lo", s_lo, 32'hFFFF_FFFA);

        launch_and_count(4'd2, 32'hFFFF_FFFE, 32'd3, 8, nbusy);
        check("multu_busy_len", 32'(nbusy), 32'd5);
        check("multu_hi", s_hi, 32'h0000_0002);
        check("multu_lo", s_lo, 32'hFFFF_FFFA);

        launch_and_count(4'd3, 32'hFFFF_FFF9, 32'd2, 12, nbusy);
        check("div_busy_len", 32'(nbusy), 32'd10);
        check("div_lo", s_lo, 32'hFFFF_FFFD);
        check("div_hi", s_hi, 32'hFFFF_FFFF);

        run_cycle(1'b1, 1'b1, 4'd5, 32'h11, 32'd0, 1'b0);
        run_cycle(1'b1, 1'b1, 4'd6, 32'h22, 32'd0, 1'b0);
        launch_and_count(4'd4, 32'd7, 32'd0, 12, nbusy);
        check("divu0_busy_len", 32'(nbusy), 32'd10);
        check("divu0_hi", s_hi, 32'h11);
        check("divu0_lo", s_lo, 32'h22);

        run_cycle(1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
        run_cycle(1'b1, 1'b1, 4'd7, 32'd0, 32'd0, 1'b0);
        check("mfhi_after_mthi", s_md_rd, 32'hDEAD_BEEF);

        launch_and_count(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 12, nbusy);
        check("div_ovf_lo", s_lo, 32'h8000_0000);
        check("div_ovf_hi", s_hi, 32'd0);

        // Stall window, with a rogue mult injected while busy.
        run_cycle(1'b1, 1'b1, 4'd1, 32'h10, 32'h10, 1'b1);
        nstall = s_stall ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) run_cycle(1'b1, 1'b1, 4'd1, 32'hFFFF, 32'hFFFF, 1'b1);
            else idle(1'b1);
            if (s_stall) nstall++;
        end
        check("stall_len", 32'(nstall), 32'd6);
        idle(1'b1);
        check("stall_7th", s_stall, 32'd0);
        check("busy_mult_ignored_hi", s_hi, 32'd0);
        check("busy_mult_ignored_lo", s_lo, 32'h100);

        run_cycle(1'b1, 1'b1, 4'd5, 32'h55, 32'd0, 1'b0);
        run_cycle(1'b1, 1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
        idle(1'b0);
        idle(1'b0);
        run_cycle(1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 1'b0);
        idle(1'b0);
        check("rst_mid_busy", s_busy, 32'd0);
        check("rst_mid_hi", s_hi, 32'd0);
        check("rst_mid_lo", s_lo, 32'd0);
        for (int i = 0; i < 12; i++) idle(1'b0);
        check("rst_no_commit_hi", s_hi, 32'd0);
        check("rst_no_commit_lo", s_lo, 32'd0);

        run_cycle(1'b0, 1'b1, 4'd1, 32'd9, 32'd9, 1'b0);
        idle(1'b0);
        check("rst_beats_start", s_busy, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            run_cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) != 0), op,
                      pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
